canvas_write_sched: RTL and testbench
=====================================

# canvas_write_sched

Scheduler for the pixel framebuffer's write port. It accepts brush-write requests from the MCU link through a small FIFO and runs a full-canvas clear sweep on command. It issues at most one write per write slot offered by the pixel store. It sits between the SPI/command decoder and the pixel store's `brush`/`wx`/`wy`/`newColor` inputs.

## Interface
Parameters:
- `FIFO_DEPTH`, 4: brush-request FIFO entries (power of two, ≥2).
- `MAX_COORDINATE`, 127: largest legal canvas coordinate; the canvas is `(MAX_COORDINATE+1)²` pixels.

Ports:
- `clk`  in  1: system clock. One clock domain; all logic on its rising edge.
- `reset`  in  1: synchronous, active-high.
- `reqValid`  in  1: brush request valid.
- `reqReady`  out  1: request accepted at this edge when `reqValid & reqReady`.
- `reqX`, `reqY`  in  8: request coordinates.
- `reqColor`  in  3: request color code.
- `clearStart`  in  1: one-cycle pulse that starts a canvas clear.
- `clearColor`  in  3: fill color, sampled when `clearStart` is honoured.
- `clearBusy`  out  1: clear sweep in progress.
- `writeSlot`  in  1: high in each cycle in which the pixel store samples the write inputs.
- `brush`  out  1: write enable to the pixel store.
- `wx`, `wy`  out  8: write coordinates.
- `newColor`  out  3: write color.

## Operation
- States: IDLE and CLEAR. Reset enters IDLE and empties the FIFO.
- `reqReady = !reset & state==IDLE & !clearStart & !full`. This is not pop-aware: a full FIFO stalls the request even in a cycle that pops.
- Out-of-range requests (`reqX` or `reqY` > `MAX_COORDINATE`) are handshaken normally but discarded, never enqueued.
- IDLE, no `clearStart`:
  - `wx`/`wy`/`newColor` show the FIFO head (0 when the FIFO is empty).
  - `brush = writeSlot & !empty`.
  - When `brush` is high, the head pops at the edge.
  - Issue order is strictly FIFO.
- IDLE, `clearStart` high:
  - `brush = 0` that cycle.
  - At the edge: flush the FIFO, latch `clearColor`, zero `clrX`/`clrY`, go to CLEAR.
- CLEAR:
  - `wx = clrX`, `wy = clrY`, `newColor` = latched color, `brush = writeSlot`.
  - On each issued write, `clrX` increments. At `MAX_COORDINATE` it wraps to 0 and `clrY` increments.
  - The write to (`MAX_COORDINATE`, `MAX_COORDINATE`) returns the block to IDLE at that edge.
  - A clear is exactly `(MAX_COORDINATE+1)²` writes, row-major from (0,0).
  - `clearStart` is ignored while in CLEAR.
  - `reqReady = 0` throughout CLEAR.
- `clearBusy = (state==CLEAR)`.
- Reset mid-clear aborts the sweep: IDLE, FIFO empty, counters 0. The partially cleared canvas is left as is.

## Timing
- Reset values: `reqReady` 0, `brush` 0, `clearBusy` 0, `wx`/`wy`/`newColor` 0.
- `brush`, `wx`, `wy`, `newColor`, `reqReady` are combinational from registered state plus `writeSlot`/`clearStart`. No input-to-output path exists except through those two signals.
- Brush latency: a request accepted at edge t appears at the FIFO head in cycle t+1. It issues in the first `writeSlot` cycle ≥ t+1 in which it is the head.
- `clearBusy` rises the cycle after `clearStart` and falls the cycle after the final sweep write.
- With `writeSlot` every other cycle, a 128×128 clear takes 32768 ± 1 cycles.
- Simultaneous push and pop in IDLE is legal when not full. Occupancy is unchanged and the popped entry is the older one.

## Test plan
- Reset: hold `reset` 3 cycles with `reqValid=1`, `writeSlot=1` → `reqReady`, `brush`, `clearBusy` stay 0; FIFO empty afterwards (no `brush` on later slots).
- Single stroke: push (5,9,color 3), `writeSlot` every other cycle → exactly one `brush` cycle with `wx=5`, `wy=9`, `newColor=3`; none after.
- Backpressure and order: `writeSlot=0`, offer 5 requests → 4 accepted, `reqReady=0` on the 5th. Enable slots → writes issue in push order, then the 5th is accepted and issued.
- Range filter: push (128,0) then (3,200) then (127,127,color 6) → only (127,127,6) is written.
- Clear: queue 2 requests, pulse `clearStart` with `clearColor=2` → FIFO flushed. First write (0,0,2), second (1,0,2), 129th (0,1,2), last (127,127,2); exactly 16384 `brush` cycles. `clearBusy` high throughout, `reqReady` 0. A second `clearStart` mid-sweep has no effect.
- Reset at sweep write 1000 → next cycle `clearBusy=0`, no further `brush`. A new request then issues normally.

Source files
------------

// File: rtl/canvas_write_sched.sv
// Write-port scheduler for the pixel framebuffer: queues brush requests in a small FIFO
// and runs a row-major full-canvas clear sweep, issuing at most one write per store slot.
module canvas_write_sched #(
    parameter int unsigned FIFO_DEPTH     = 4,
    parameter int unsigned MAX_COORDINATE = 127
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       reqValid,
    output logic       reqReady,
    input  logic [7:0] reqX,
    input  logic [7:0] reqY,
    input  logic [2:0] reqColor,
    input  logic       clearStart,
    input  logic [2:0] clearColor,
    output logic       clearBusy,
    input  logic       writeSlot,
    output logic       brush,
    output logic [7:0] wx,
    output logic [7:0] wy,
    output logic [2:0] newColor
);

    localparam int unsigned AW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [7:0]  MaxCoord = 8'(MAX_COORDINATE);
    localparam logic [AW:0] FullCnt  = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [0:0] {StIdle, StClear} state_e;

    state_e state_q, state_d;

    logic [7:0]    fifo_x_q [FIFO_DEPTH];
    logic [7:0]    fifo_y_q [FIFO_DEPTH];
    logic [2:0]    fifo_c_q [FIFO_DEPTH];
    logic [AW-1:0] rd_ptr_q, wr_ptr_q;
    logic [AW:0]   count_q;

    logic [7:0] clr_x_q, clr_y_q;
    logic [2:0] clr_color_q;

    logic empty, full, in_range, push, pop, start_clear, sweep_write, sweep_last;

    assign empty       = (count_q == '0);
    assign full        = (count_q == FullCnt);
    assign in_range    = (reqX <= MaxCoord) && (reqY <= MaxCoord);
    // Out-of-range requests still complete the handshake; they are just never stored.
    assign push        = reqValid && reqReady && in_range;
    assign pop         = brush && (state_q == StIdle);
    assign start_clear = !reset && (state_q == StIdle) && clearStart;
    assign sweep_write = (state_q == StClear) && writeSlot;
    assign sweep_last  = (clr_x_q == MaxCoord) && (clr_y_q == MaxCoord);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (clearStart) state_d = StClear;
            StClear: if (writeSlot && sweep_last) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        reqReady  = 1'b0;
        brush     = 1'b0;
        wx        = '0;
        wy        = '0;
        newColor  = '0;
        clearBusy = (state_q == StClear);
        unique case (state_q)
            StIdle: begin
                reqReady = !reset && !clearStart && !full;
                brush    = !reset && writeSlot && !empty && !clearStart;
                if (!empty) begin
                    wx       = fifo_x_q[rd_ptr_q];
                    wy       = fifo_y_q[rd_ptr_q];
                    newColor = fifo_c_q[rd_ptr_q];
                end
            end
            StClear: begin
                brush    = !reset && writeSlot;
                wx       = clr_x_q;
                wy       = clr_y_q;
                newColor = clr_color_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_x_q[wr_ptr_q] <= reqX;
            fifo_y_q[wr_ptr_q] <= reqY;
            fifo_c_q[wr_ptr_q] <= reqColor;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            clr_x_q     <= '0;
            clr_y_q     <= '0;
            clr_color_q <= '0;
        end else if (start_clear) begin
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            clr_x_q     <= '0;
            clr_y_q     <= '0;
            clr_color_q <= clearColor;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_q + (AW + 1)'(push) - (AW + 1)'(pop);
            if (sweep_write) begin
                if (clr_x_q == MaxCoord) begin
                    clr_x_q <= '0;
                    clr_y_q <= (clr_y_q == MaxCoord) ? '0 : clr_y_q + 8'd1;
                end else begin
                    clr_x_q <= clr_x_q + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_canvas_write_sched.sv
// Scoreboard bench for canvas_write_sched: expected writes are queued as stimulus is
// accepted and compared against every brush cycle the DUT issues.
module tb_canvas_write_sched;

    typedef struct packed {
        logic [7:0] x;
        logic [7:0] y;
        logic [2:0] c;
    } wr_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       reqValid = 1'b0;
    logic       reqReady;
    logic [7:0] reqX = '0;
    logic [7:0] reqY = '0;
    logic [2:0] reqColor = '0;
    logic       clearStart = 1'b0;
    logic [2:0] clearColor = '0;
    logic       clearBusy;
    logic       writeSlot = 1'b0;
    logic       brush;
    logic [7:0] wx, wy;
    logic [2:0] newColor;

    int  n_checks = 0;
    int  n_fail = 0;
    int  brush_cnt = 0;
    int  slot_mode = 0;  // 0 off, 1 every cycle, 2 every other cycle
    wr_t exp_q[$];

    canvas_write_sched #(.FIFO_DEPTH(4), .MAX_COORDINATE(127)) dut (
        .clk       (clk),
        .reset     (reset),
        .reqValid  (reqValid),
        .reqReady  (reqReady),
        .reqX      (reqX),
        .reqY      (reqY),
        .reqColor  (reqColor),
        .clearStart(clearStart),
        .clearColor(clearColor),
        .clearBusy (clearBusy),
        .writeSlot (writeSlot),
        .brush     (brush),
        .wx        (wx),
        .wy        (wy),
        .newColor  (newColor)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    initial begin : slot_gen
        bit phase = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            phase = ~phase;
            case (slot_mode)
                1:       writeSlot = 1'b1;
                2:       writeSlot = phase;
                default: writeSlot = 1'b0;
            endcase
        end
    end

    // Every issued write must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!reset && brush) begin
            brush_cnt++;
            if (exp_q.size() == 0) begin
                check_val("spurious_brush", 1, 0);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check_val("wx", int'(wx), int'(e.x));
                check_val("wy", int'(wy), int'(e.y));
                check_val("newColor", int'(newColor), int'(e.c));
            end
        end
    end

    task automatic push_req(input logic [7:0] x, input logic [7:0] y, input logic [2:0] c);
        bit done = 1'b0;
        @(posedge clk);
        #1;
        reqValid = 1'b1;
        reqX = x;
        reqY = y;
        reqColor = c;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (reqReady) begin
                done = 1'b1;
                if (x <= 8'd127 && y <= 8'd127) exp_q.push_back('{x: x, y: y, c: c});
            end
        end
        if (!done) check_val("push_timeout", 0, 1);
        @(posedge clk);
        #1;
        reqValid = 1'b0;
    endtask

    task automatic wait_drain(input int bound);
        bit done = 1'b0;
        for (int i = 0; i < bound && !done; i++) begin
            @(negedge clk);
            #1;
            if (exp_q.size() == 0) done = 1'b1;
        end
        check_val("drain_left", exp_q.size(), 0);
    endtask

    task automatic load_sweep(input logic [2:0] c);
        for (int y = 0; y < 128; y++)
            for (int x = 0; x < 128; x++)
                exp_q.push_back('{x: 8'(x), y: 8'(y), c: c});
    endtask

    initial begin : stim
        int base;
        bit done;

        // Reset held with traffic present.
        reqValid = 1'b1;
        reqX = 8'd1;
        reqY = 8'd1;
        slot_mode = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_val("rst_reqReady", int'(reqReady), 0);
            check_val("rst_brush", int'(brush), 0);
            check_val("rst_clearBusy", int'(clearBusy), 0);
            check_val("rst_wxwyc", int'({wx, wy, newColor}), 0);
        end
        @(posedge clk);
        #1;
        reqValid = 1'b0;
        reset = 1'b0;
        repeat (6) @(negedge clk);
        check_val("post_rst_brushes", brush_cnt, 0);

        // Single stroke.
        slot_mode = 2;
        base = brush_cnt;
        push_req(8'd5, 8'd9, 3'd3);
        wait_drain(50);
        repeat (10) @(negedge clk);
        check_val("single_count", brush_cnt - base, 1);

        // Backpressure and ordering.
        slot_mode = 0;
        repeat (3) @(posedge clk);
        base = brush_cnt;
        for (int i = 0; i < 4; i++) push_req(8'(10 + i), 8'(20 + i), 3'(i));
        @(posedge clk);
        #1;
        reqValid = 1'b1;
        reqX = 8'd50;
        reqY = 8'd60;
        reqColor = 3'd7;
        @(negedge clk);
        check_val("full_reqReady", int'(reqReady), 0);
        reqValid = 1'b0;
        slot_mode = 1;
        push_req(8'd50, 8'd60, 3'd7);
        wait_drain(50);
        check_val("order_count", brush_cnt - base, 5);

        // Range filter.
        slot_mode = 2;
        base = brush_cnt;
        push_req(8'd128, 8'd0, 3'd1);
        push_req(8'd3, 8'd200, 3'd4);
        push_req(8'd127, 8'd127, 3'd6);
        wait_drain(50);
        repeat (6) @(negedge clk);
        check_val("range_count", brush_cnt - base, 1);

        // Full clear with queued requests flushed.
        slot_mode = 0;
        repeat (3) @(posedge clk);
        push_req(8'd1, 8'd2, 3'd5);
        push_req(8'd3, 8'd4, 3'd5);
        @(posedge clk);
        #1;
        slot_mode = 1;
        clearStart = 1'b1;
        clearColor = 3'd2;
        @(negedge clk);
        check_val("clrstart_brush", int'(brush), 0);
        check_val("clrstart_reqReady", int'(reqReady), 0);
        exp_q.delete();
        load_sweep(3'd2);
        base = brush_cnt;
        @(posedge clk);
        #1;
        clearStart = 1'b0;
        clearColor = 3'd0;
        done = 1'b0;
        for (int i = 0; i < 20000 && !done; i++) begin
            @(negedge clk);
            if (i % 4096 == 0) begin
                check_val("clr_busy", int'(clearBusy), 1);
                check_val("clr_reqReady", int'(reqReady), 0);
            end
            #1;
            if (i == 500) begin
                clearStart = 1'b1;
                clearColor = 3'd5;
            end else begin
                clearStart = 1'b0;
                clearColor = 3'd0;
            end
            if (exp_q.size() == 0) done = 1'b1;
        end
        check_val("clr_left", exp_q.size(), 0);
        @(negedge clk);
        check_val("clr_busy_fall", int'(clearBusy), 0);
        check_val("clr_brush_after", int'(brush), 0);
        check_val("clr_count", brush_cnt - base, 16384);

        // Reset in the middle of a sweep.
        @(posedge clk);
        #1;
        clearStart = 1'b1;
        clearColor = 3'd7;
        @(negedge clk);
        load_sweep(3'd7);
        base = brush_cnt;
        @(posedge clk);
        #1;
        clearStart = 1'b0;
        done = 1'b0;
        for (int i = 0; i < 3000 && !done; i++) begin
            @(negedge clk);
            #1;
            if (brush_cnt - base == 999) done = 1'b1;
        end
        check_val("sweep_999", brush_cnt - base, 999);
        @(posedge clk);
        #1;
        reset = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check_val("abort_busy", int'(clearBusy), 0);
        check_val("abort_brush", int'(brush), 0);
        check_val("abort_wx", int'(wx), 0);
        base = brush_cnt;
        repeat (20) @(negedge clk);
        check_val("abort_quiet", brush_cnt - base, 0);
        push_req(8'd10, 8'd20, 3'd5);
        wait_drain(50);
        check_val("abort_newreq", brush_cnt - base, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
